// File: rtl/raquette_ctrl.sv
// Paddle motion controller: button synchronise/debounce, per-frame move FSM
// with speed ramp, and wall-clamped 11-bit position output.
module raquette_ctrl #(
  parameter int SCREEN_W        = 640,
  parameter int PADDLE_W        = 80,
  parameter int POS_INIT        = 280,
  parameter int SPEED_MIN       = 2,
  parameter int SPEED_MAX       = 12,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        frame_tick,
  input  logic        game_run,
  input  logic        centre_req,
  output logic [10:0] pos_raquette,
  output logic [4:0]  speed,
  output logic        moving,
  output logic        at_left,
  output logic        at_right
);

  localparam int MAX_POS = SCREEN_W - PADDLE_W;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]  SPD_MIN = 5'(SPEED_MIN);
  localparam logic [4:0]  SPD_MAX = 5'(SPEED_MAX);
  localparam logic [11:0] MAX12   = 12'(MAX_POS);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  // Bit 0 carries the left button, bit 1 the right button.
  logic [1:0]    sync1, sync2, db;
  logic [CW-1:0] cnt [2];

  state_t      state_q, state_d;
  logic [4:0]  speed_d;
  logic [10:0] pos_d;
  logic [11:0] pos12, step12, sum12;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_right, btn_left};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed;
    pos_d   = pos_raquette;
    pos12   = {1'b0, pos_raquette};
    step12  = '0;
    sum12   = '0;
    if (centre_req) begin
      state_d = IDLE;
      speed_d = SPD_MIN;
      pos_d   = 11'(POS_INIT);
    end else if (!game_run) begin
      state_d = IDLE;
      speed_d = SPD_MIN;
    end else if (frame_tick) begin
      if (db[0] && !db[1]) begin
        state_d = MOVE_L;
        if (state_q != MOVE_L) speed_d = SPD_MIN;
        else speed_d = (speed >= SPD_MAX) ? SPD_MAX : speed + 5'd1;
        step12 = {7'b0, speed_d};
        pos_d  = (pos12 < step12) ? 11'd0 : 11'(pos12 - step12);
      end else if (db[1] && !db[0]) begin
        state_d = MOVE_R;
        if (state_q != MOVE_R) speed_d = SPD_MIN;
        else speed_d = (speed >= SPD_MAX) ? SPD_MAX : speed + 5'd1;
        step12 = {7'b0, speed_d};
        sum12  = pos12 + step12;
        pos_d  = (sum12 > MAX12) ? 11'(MAX_POS) : 11'(sum12);
      end else begin
        state_d = IDLE;
        speed_d = SPD_MIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      speed        <= SPD_MIN;
      pos_raquette <= 11'(POS_INIT);
      at_left      <= (POS_INIT == 0);
      at_right     <= (POS_INIT == MAX_POS);
    end else begin
      state_q      <= state_d;
      speed        <= speed_d;
      pos_raquette <= pos_d;
      at_left      <= (pos_d == 11'd0);
      at_right     <= (pos_d == 11'(MAX_POS));
    end
  end

  assign moving = (state_q != IDLE);

endmodule
